// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo types and default sizing constants
package tomasulo_pkg;

  localparam int CDB_N     = 4;
  localparam int CDB_SCH_W = 8;
  localparam int CDB_OWN_W = $clog2(CDB_N);

  typedef logic [CDB_SCH_W-1:0] cdb_sch_t;
  typedef logic [CDB_OWN_W-1:0] cdb_own_t;

endpackage

// File: rtl/tomasulo_cdb_sch.sv
// rtl/tomasulo_cdb_sch.sv - books future CDB slots for fixed-latency FUs
// and publishes the booking vector plus the owner of the current CDB slot.
module tomasulo_cdb_sch
  import tomasulo_pkg::*;
#(
  parameter int N         = CDB_N,
  parameter int SCH_W     = CDB_SCH_W,
  parameter int LAT [N]   = '{1, 2, 2, 4},
  localparam int OWN_W    = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W    = $clog2(SCH_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     cdb_req,
  output logic [N-1:0]     cdb_gnt,
  output logic [SCH_W-1:0] sch_r,
  output logic             cdb_own_vld_r,
  output logic [OWN_W-1:0] cdb_own_r,
  output logic [CNT_W-1:0] busy_cnt_r
);

  for (genvar i = 0; i < N; i++) begin : g_lat_chk
    if (LAT[i] < 0 || LAT[i] + 2 > SCH_W) begin : g_bad
      $error("tomasulo_cdb_sch: LAT[%0d]=%0d does not fit SCH_W=%0d", i, LAT[i], SCH_W);
    end
  end

  logic [OWN_W-1:0] own_r [SCH_W];
  logic [OWN_W-1:0] ptr_r;
  logic [OWN_W-1:0] ptr_nxt;
  logic [N-1:0]     gnt;
  logic [SCH_W-1:1] claim;
  logic [OWN_W-1:0] claim_own [1:SCH_W-1];
  logic [SCH_W-1:0] sch_nxt;
  logic [CNT_W-1:0] busy_nxt;

  // Rotated walk: step s visits station (ptr_r+s) mod N; the inner match keeps
  // every slot index a constant so each station only looks at its own target.
  always_comb begin
    logic hit;
    hit     = 1'b0;
    gnt     = '0;
    claim   = '0;
    ptr_nxt = ptr_r;
    for (int k = 1; k < SCH_W; k++) claim_own[k] = '0;
    for (int s = 0; s < N; s++) begin
      for (int j = 0; j < N; j++) begin
        if (j == (int'(ptr_r) + s) % N) begin
          if (cdb_req[j] && !sch_r[LAT[j]+1] && !claim[LAT[j]+1]) begin
            gnt[j]                = 1'b1;
            claim[LAT[j]+1]       = 1'b1;
            claim_own[LAT[j]+1]   = OWN_W'(j);
            if (!hit) begin
              hit     = 1'b1;
              ptr_nxt = OWN_W'((j + 1) % N);
            end
          end
        end
      end
    end
  end

  always_comb begin
    sch_nxt = '0;
    for (int k = 0; k < SCH_W - 1; k++) sch_nxt[k] = sch_r[k+1] | claim[k+1];
  end

  always_comb begin
    busy_nxt = '0;
    for (int k = 0; k < SCH_W; k++) busy_nxt = busy_nxt + CNT_W'(sch_nxt[k]);
  end

  // Stations may still be requesting while reset is held; never grant then.
  assign cdb_gnt       = rst ? gnt : '0;
  assign cdb_own_vld_r = sch_r[0];
  assign cdb_own_r     = own_r[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sch_r      <= '0;
      busy_cnt_r <= '0;
      ptr_r      <= '0;
    end else begin
      sch_r      <= sch_nxt;
      busy_cnt_r <= busy_nxt;
      ptr_r      <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SCH_W; k++) own_r[k] <= '0;
    end else begin
      for (int k = 0; k < SCH_W - 1; k++)
        own_r[k] <= claim[k+1] ? claim_own[k+1] : own_r[k+1];
      own_r[SCH_W-1] <= '0;
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb_sch.sv
// tb/tb_tomasulo_cdb_sch.sv - directed self-checking bench for tomasulo_cdb_sch
module tb_tomasulo_cdb_sch;
  import tomasulo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  cdb_sch_t   sch;
  logic       vld;
  cdb_own_t   own;
  logic [3:0] busy;

  int n_chk  = 0;
  int n_fail = 0;

  int lat_m [4] = '{1, 2, 2, 4};
  logic       book_vld [32];
  int         book_own [32];

  tomasulo_cdb_sch #(.N(4), .SCH_W(8), .LAT('{1, 2, 2, 4})) dut (
    .clk           (clk),
    .rst           (rst),
    .cdb_req       (req),
    .cdb_gnt       (gnt),
    .sch_r         (sch),
    .cdb_own_vld_r (vld),
    .cdb_own_r     (own),
    .busy_cnt_r    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] r);
    req = r;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with all stations requesting
    #3;
    chk("rst_sch", sch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_own", own, 0);
    chk("rst_gnt", gnt, 0);

    // single booking by station 1
    do_reset();
    drive(4'b0010); chk("t1_gnt", gnt, 4'b0010);
    tick(); drive(4'b0000); chk("t1_sch1", sch, 8'h04); chk("t1_busy1", busy, 1);
    tick(); chk("t1_sch2", sch, 8'h02); chk("t1_vld2", vld, 0);
    tick(); chk("t1_vld3", vld, 1); chk("t1_own3", own, 1); chk("t1_busy3", busy, 1);
    tick(); chk("t1_vld4", vld, 0); chk("t1_busy4", busy, 0);

    // equal-latency contention, rotating priority
    do_reset();
    for (int t = 0; t < 8; t++) begin
      drive(4'b0110);
      chk($sformatf("t2_gnt%0d", t), gnt, (t % 2 == 0) ? 4'b0010 : 4'b0100);
      if (t >= 3) begin
        chk($sformatf("t2_vld%0d", t), vld, 1);
        chk($sformatf("t2_own%0d", t), own, ((t - 3) % 2 == 0) ? 1 : 2);
      end
      tick();
    end

    // distinct latencies granted together
    do_reset();
    drive(4'b1001); chk("t3_gnt", gnt, 4'b1001);
    tick(); drive(4'b0000); chk("t3_sch1", sch, 8'h12); chk("t3_busy1", busy, 2);
    tick(); chk("t3_vld2", vld, 1); chk("t3_own2", own, 0);
    tick(); chk("t3_vld3", vld, 0);
    tick(); tick(); chk("t3_vld5", vld, 1); chk("t3_own5", own, 3);

    // slot collision
    do_reset();
    drive(4'b1000); chk("t4_gnt0", gnt, 4'b1000);
    tick(); drive(4'b0000);
    tick(); drive(4'b0010); chk("t4_gnt2", gnt, 4'b0000); chk("t4_sch2", sch, 8'h08);
    tick(); drive(4'b0010); chk("t4_gnt3", gnt, 4'b0010);
    tick(); drive(4'b0000);
    tick(); chk("t4_vld5", vld, 1); chk("t4_own5", own, 3);
    tick(); chk("t4_vld6", vld, 1); chk("t4_own6", own, 1);

    // all stations requesting continuously
    do_reset();
    for (int i = 0; i < 32; i++) begin
      book_vld[i] = 1'b0;
      book_own[i] = 0;
    end
    for (int t = 0; t < 20; t++) begin
      drive(4'b1111);
      if (t == 0) chk("t5_gnt0", gnt, 4'b1011);
      chk($sformatf("t5_vld%0d", t), vld, (t >= 2) ? 1 : 0);
      if (book_vld[t]) chk($sformatf("t5_own%0d", t), own, book_own[t]);
      chk($sformatf("t5_busy%0d", t), (busy <= 4'd8) ? 1 : 0, 1);
      chk($sformatf("t5_pair%0d", t), gnt[1] & gnt[2], 0);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          chk($sformatf("t5_dbl%0d_%0d", t, i), book_vld[t + lat_m[i] + 1], 0);
          book_vld[t + lat_m[i] + 1] = 1'b1;
          book_own[t + lat_m[i] + 1] = i;
        end
      end
      tick();
    end

    // asynchronous reset mid-operation
    do_reset();
    drive(4'b1011); chk("t6_gnt0", gnt, 4'b1011);
    tick(); drive(4'b0000); chk("t6_sch1", sch, 8'h16); chk("t6_busy1", busy, 3);
    tick();
    req = 4'b1111;
    rst = 1'b0;
    #1;
    chk("t6_sch_rst", sch, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_vld_rst", vld, 0);
    chk("t6_gnt_rst", gnt, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(4'b0001); chk("t6_gnt_rel", gnt, 4'b0001);
    tick(); drive(4'b0000); chk("t6_sch_rel", sch, 8'h02);
    tick(); chk("t6_vld_rel", vld, 1); chk("t6_own_rel", own, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
